// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment types, active-low digit patterns and monitor states.
package seg7_pkg;
  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG7_PATTERN [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam seg_t SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} mon_state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low 7-segment pattern to digit, with a legal-pattern flag.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);
  always_comb begin
    digit = '0;
    legal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG7_PATTERN[i]) begin
        digit = 4'(i);
        legal = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg7_sequence_monitor.sv
// seg7_sequence_monitor: glitch-filtered 7-segment read-back that tracks a programmed digit sequence.
// Define SEG7_MON_REVERSE_EN to accept a direction reversal while locked as a legal step.
module seg7_sequence_monitor
  import seg7_pkg::*;
#(
  parameter int          NUM_DIGITS    = 5,
  parameter logic [31:0] SEQ           = 32'h00052849,
  parameter int          STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        locked,
  output logic [2:0]  position,
  output logic        dir_fwd,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] step_count
);
`ifdef SEG7_MON_REVERSE_EN
  localparam bit REVERSE_EN = 1'b1;
`else
  localparam bit REVERSE_EN = 1'b0;
`endif
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  seg_t seg_q, acc;
  logic [CW-1:0] cnt;
  mon_state_t state, state_d;
  digit_t dec;
  logic legal, same, accept, hit, dir_d, err_d;
  logic [2:0] idx, nxt, prv, exp_pos, rev_pos, pos_d;
  logic [7:0] err_count_d;
  logic [15:0] step_count_d;

  // index 0 lives in the highest used nibble
  function automatic digit_t seq_at(logic [2:0] i);
    return SEQ[(NUM_DIGITS - 1 - int'(i)) * 4 +: 4];
  endfunction

  seg7_decode u_decode (.seg(seg_q), .digit(dec), .legal(legal));

  // accept on the edge that completes STABLE_CYCLES identical samples
  assign same = seg_n == seg_q;
  assign accept = same && cnt >= CNT_PRE && seg_q != acc;
  assign locked = state == LOCKED;
  assign nxt = position == LAST ? 3'd0 : position + 3'd1;
  assign prv = position == 3'd0 ? LAST : position - 3'd1;
  assign exp_pos = dir_fwd ? nxt : prv;
  assign rev_pos = dir_fwd ? prv : nxt;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (legal && seq_at(3'(i)) == dec) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state;
    pos_d = position;
    dir_d = dir_fwd;
    err_d = 1'b0;
    err_count_d = err_count;
    step_count_d = step_count;
    if (accept) begin
      case (state)
        SEARCH: begin
          state_d = hit ? TRACK : SEARCH;
          pos_d = hit ? idx : position;
        end
        TRACK: begin
          if (hit && idx == nxt) begin
            state_d = LOCKED;
            pos_d = nxt;
            dir_d = 1'b1;
          end else if (hit && idx == prv) begin
            state_d = LOCKED;
            pos_d = prv;
            dir_d = 1'b0;
          end else if (hit) begin
            pos_d = idx;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (hit && idx == exp_pos) begin
            pos_d = exp_pos;
            step_count_d = step_count + 16'd1;
          end else if (REVERSE_EN && hit && idx == rev_pos) begin
            pos_d = rev_pos;
            dir_d = !dir_fwd;
            step_count_d = step_count + 16'd1;
          end else begin
            err_d = 1'b1;
            err_count_d = err_count == 8'hFF ? err_count : err_count + 8'd1;
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      acc <= SEG_BLANK;
      cnt <= '0;
      state <= SEARCH;
      digit <= '0;
      digit_valid <= 1'b0;
      position <= '0;
      dir_fwd <= 1'b0;
      err <= 1'b0;
      err_count <= '0;
      step_count <= '0;
    end else begin
      seg_q <= seg_n;
      cnt <= !same ? '0 : cnt == CNT_MAX ? cnt : cnt + CW'(1);
      acc <= accept ? seg_q : acc;
      digit <= accept && legal ? dec : digit;
      digit_valid <= accept && legal;
      state <= state_d;
      position <= pos_d;
      dir_fwd <= dir_d;
      err <= err_d;
      err_count <= err_count_d;
      step_count <= step_count_d;
    end
  end
endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// tb_seg7_sequence_monitor: vector table, reset corner case and random stimulus against a behavioural model.
module tb_seg7_sequence_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] seg_n = 7'h7F;
  logic [3:0] digit;
  logic digit_valid, locked, dir_fwd, err;
  logic [2:0] position;
  logic [7:0] err_count;
  logic [15:0] step_count;

  seg7_sequence_monitor dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .digit(digit), .digit_valid(digit_valid),
    .locked(locked), .position(position), .dir_fwd(dir_fwd), .err(err),
    .err_count(err_count), .step_count(step_count)
  );

  always #5 clk = ~clk;

`ifdef SEG7_MON_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  localparam int N = 5;
  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  int sq [5] = '{5, 2, 8, 4, 9};
  int checks = 0;
  int errors = 0;

  int m_state, m_pos, m_digit, m_errc, m_step;
  bit m_dir, m_valid, m_err;
  logic [6:0] m_acc;
  logic [6:0] hist [$];

  typedef struct {
    int pat; int hold; int digit; int pulses; int pos; int lck; int dir; int errc; int step;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == PAT[i]) return i;
    return -1;
  endfunction

  function automatic int find(input int d);
    for (int i = 0; i < N; i++) if (sq[i] == d) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [6:0] s, input bit r);
    int d, ix, nx, pv, ex, rv;
    bit stable;
    m_valid = 0;
    m_err = 0;
    if (r) begin
      m_state = 0; m_pos = 0; m_digit = 0; m_errc = 0; m_step = 0; m_dir = 0;
      m_acc = 7'h7F;
      hist.delete();
      return;
    end
    hist.push_back(s);
    if (hist.size() > 4) void'(hist.pop_front());
    stable = hist.size() == 4;
    foreach (hist[i]) if (hist[i] != s) stable = 0;
    if (!stable || s == m_acc) return;
    m_acc = s;
    d = dec(s);
    if (d >= 0) begin
      m_digit = d;
      m_valid = 1;
    end
    ix = d >= 0 ? find(d) : -1;
    nx = (m_pos + 1) % N;
    pv = (m_pos + N - 1) % N;
    ex = m_dir ? nx : pv;
    rv = m_dir ? pv : nx;
    if (m_state == 0) begin
      if (ix >= 0) begin m_state = 1; m_pos = ix; end
    end else if (m_state == 1) begin
      if (ix == nx) begin m_state = 2; m_pos = nx; m_dir = 1; end
      else if (ix == pv) begin m_state = 2; m_pos = pv; m_dir = 0; end
      else if (ix >= 0) m_pos = ix;
      else m_state = 0;
    end else begin
      if (ix == ex) begin m_pos = ex; m_step = (m_step + 1) % 65536; end
      else if (REV && ix == rv) begin m_pos = rv; m_dir = !m_dir; m_step = (m_step + 1) % 65536; end
      else begin m_err = 1; if (m_errc < 255) m_errc++; m_state = 0; end
    end
  endtask

  task automatic compare_all();
    check("digit", int'(digit), m_digit);
    check("digit_valid", int'(digit_valid), int'(m_valid));
    check("locked", int'(locked), int'(m_state == 2));
    check("position", int'(position), m_pos);
    check("dir_fwd", int'(dir_fwd), int'(m_dir));
    check("err", int'(err), int'(m_err));
    check("err_count", int'(err_count), m_errc);
    check("step_count", int'(step_count), m_step);
  endtask

  task automatic tick(input logic [6:0] s, input bit r);
    seg_n = s;
    reset = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    compare_all();
  endtask

  task automatic add(input int p, input int h, input int dg, input int pl, input int ps,
                     input int lk, input int dr, input int ec, input int st);
    tbl.push_back('{p, h, dg, pl, ps, lk, dr, ec, st});
  endtask

  initial begin
    int pulses, n, cur, r, h;
    bit dr;
    logic [6:0] pat;
    add(5, 4, 5, 1, 0, 0, 0, 0, 0);
    add(2, 6, 2, 1, 1, 1, 1, 0, 0);
    add(8, 6, 8, 1, 2, 1, 1, 0, 1);
    add(4, 6, 4, 1, 3, 1, 1, 0, 2);
    add(9, 6, 9, 1, 4, 1, 1, 0, 3);
    add(5, 6, 5, 1, 0, 1, 1, 0, 4);
    add(2, 6, 2, 1, 1, 1, 1, 0, 5);
    add(1, 6, 1, 1, 1, 0, 1, 1, 5);
    add(5, 6, 5, 1, 0, 0, 1, 1, 5);
    add(9, 6, 9, 1, 4, 1, 0, 1, 5);
    add(4, 6, 4, 1, 3, 1, 0, 1, 6);
    add(1, 6, 1, 1, 3, 0, 0, 2, 6);
    add(2, 6, 2, 1, 1, 0, 0, 2, 6);
    add(8, 6, 8, 1, 2, 1, 1, 2, 6);
    if (REV) begin
      add(2, 6, 2, 1, 1, 1, 0, 2, 7);
      add(8, 2, 2, 0, 1, 1, 0, 2, 7);
      add(2, 6, 2, 0, 1, 1, 0, 2, 7);
    end else begin
      add(2, 6, 2, 1, 2, 0, 1, 3, 6);
      add(8, 2, 2, 0, 2, 0, 1, 3, 6);
      add(2, 6, 2, 0, 2, 0, 1, 3, 6);
    end
    repeat (3) tick(7'h7F, 1'b1);
    for (int k = 0; k < tbl.size(); k++) begin
      pulses = 0;
      repeat (tbl[k].hold) begin
        tick(PAT[tbl[k].pat], 1'b0);
        pulses += int'(digit_valid);
      end
      check($sformatf("tbl%0d.digit", k), int'(digit), tbl[k].digit);
      check($sformatf("tbl%0d.pulses", k), pulses, tbl[k].pulses);
      check($sformatf("tbl%0d.position", k), int'(position), tbl[k].pos);
      check($sformatf("tbl%0d.locked", k), int'(locked), tbl[k].lck);
      check($sformatf("tbl%0d.dir_fwd", k), int'(dir_fwd), tbl[k].dir);
      check($sformatf("tbl%0d.err_count", k), int'(err_count), tbl[k].errc);
      check($sformatf("tbl%0d.step_count", k), int'(step_count), tbl[k].step);
    end
    repeat (6) tick(PAT[8], 1'b0);
    repeat (6) tick(PAT[4], 1'b0);
    check("pre_reset.locked", int'(locked), 1);
    tick(PAT[4], 1'b1);
    check("reset.digit", int'(digit), 0);
    check("reset.locked", int'(locked), 0);
    check("reset.err_count", int'(err_count), 0);
    check("reset.step_count", int'(step_count), 0);
    check("reset.position", int'(position), 0);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick(PAT[4], 1'b0);
      if (digit_valid) n = i;
    end
    check("reaccept.latency", n, 4);
    check("reaccept.digit", int'(digit), 4);
    cur = 0;
    dr = 1;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        tick(PAT[$urandom_range(0, 9)], 1'b1);
      end else begin
        if (r < 65) begin
          pat = PAT[sq[cur]];
          cur = dr ? (cur + 1) % N : (cur + N - 1) % N;
          if ($urandom_range(0, 9) == 0) dr = !dr;
        end else if (r < 85) begin
          pat = PAT[$urandom_range(0, 9)];
        end else begin
          pat = 7'($urandom);
        end
        h = $urandom_range(1, 8);
        repeat (h) tick(pat, 1'b0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
